// File: rtl/sec_countdown.sv
// Seconds down-counter in the clk_50MHz domain, timed by a synchronised clk_1Hz tick.
// Optional SEC_COUNTDOWN_BCD_EN adds decimal bcd_tens/bcd_ones of remain (needs W<=6).
module sec_countdown #(
  parameter int W           = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_50MHz,
  input  logic         res,
  input  logic         clk_1Hz,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         abort,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] remain
`ifdef SEC_COUNTDOWN_BCD_EN
  ,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;
  state_t                 state_q, state_d;
  logic [W-1:0]           remain_q, remain_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // clk_1Hz is asynchronous here; only the last sync stage is used for edge detection.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], clk_1Hz};
    prev_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d  = S_IDLE;
      remain_d = '0;
      busy_d   = 1'b0;
    end else if (load) begin
      // Load restarts from any state, including the DONE cycle, and beats a tick.
      if (load_val != '0) begin
        state_d  = S_RUN;
        remain_d = load_val;
        busy_d   = 1'b1;
      end else begin
        state_d  = S_DONE;
        remain_d = '0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (tick_q) begin
            if (remain_q > W'(1)) begin
              remain_d = remain_q - W'(1);
            end else begin
              state_d  = S_DONE;
              remain_d = '0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or posedge res) begin
    if (res) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      tick_q   <= 1'b0;
      state_q  <= S_IDLE;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tick   = tick_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign remain = remain_q;

`ifdef SEC_COUNTDOWN_BCD_EN
  logic [7:0] rem8;
  always_comb begin
    rem8     = 8'(remain_q);
    bcd_tens = 4'(rem8 / 8'd10);
    bcd_ones = 4'(rem8 % 8'd10);
  end
`endif

endmodule

// File: tb/tb_sec_countdown.sv
// Scoreboard bench for sec_countdown: stimulus queues expected tick/done events,
// a negedge monitor pops and compares them (including the cycle they appear).
module tb_sec_countdown;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         clk_1Hz = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         abort = 1'b0;
  logic         tick, busy, done;
  logic [W-1:0] remain;
`ifdef SEC_COUNTDOWN_BCD_EN
  logic [3:0]   bcd_tens, bcd_ones;
`endif

  sec_countdown #(.W(W), .SYNC_STAGES(2)) dut (
    .clk_50MHz (clk),
    .res       (res),
    .clk_1Hz   (clk_1Hz),
    .load      (load),
    .load_val  (load_val),
    .abort     (abort),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .remain    (remain)
`ifdef SEC_COUNTDOWN_BCD_EN
    ,
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           c;
    logic         t;
    logic         d;
    logic         b;
    logic [W-1:0] r;
  } ev_t;

  ev_t ev_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic t, input logic d, input logic b,
                      input logic [W-1:0] r);
    ev_t e;
    e.c = c; e.t = t; e.d = d; e.b = b; e.r = r;
    ev_q.push_back(e);
  endtask

  // Monitor: any cycle with tick or done is an output event.
  always @(negedge clk) begin
    if (tick === 1'b1 || done === 1'b1) begin
      if (ev_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: tick=%0b done=%0b busy=%0b remain=%0d at cycle %0d, none expected",
                 tick, done, busy, remain, cyc);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        chk("ev_cycle", cyc, e.c);
        chk("ev_tick", int'(tick), int'(e.t));
        chk("ev_done", int'(done), int'(e.d));
        chk("ev_busy", int'(busy), int'(e.b));
        chk("ev_remain", int'(remain), int'(e.r));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One load cycle; outputs reflect it when the task returns.
  task automatic do_load(input logic [W-1:0] v);
    step();
    load = 1'b1;
    load_val = v;
    if (v == '0) push(cyc + 1, 1'b0, 1'b1, 1'b0, '0);
    step();
    load = 1'b0;
  endtask

  // Full clk_1Hz period: 26 cycles high, 26 low.
  task automatic pulse(input logic b, input logic [W-1:0] r, input logic fin);
    int k;
    step();
    k = cyc;
    clk_1Hz = 1'b1;
    push(k + 3, 1'b1, 1'b0, b, r);
    if (fin) push(k + 4, 1'b0, 1'b1, 1'b0, '0);
    wait_n(26);
    clk_1Hz = 1'b0;
    wait_n(26);
  endtask

  initial begin
    int k;
    // Reset state
    wait_n(3);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_remain", int'(remain), 0);
    res = 1'b0;
    wait_n(5);

    // Idle tick, exact latency, no tick on the falling edge
    pulse(1'b0, '0, 1'b0);

    // Countdown of 3
    do_load(6'd3);
    chk("ld3_busy", int'(busy), 1);
    chk("ld3_remain", int'(remain), 3);
    pulse(1'b1, 6'd3, 1'b0);
    chk("cnt_remain2", int'(remain), 2);
    pulse(1'b1, 6'd2, 1'b0);
    chk("cnt_remain1", int'(remain), 1);
    pulse(1'b1, 6'd1, 1'b1);
    chk("cnt_end_busy", int'(busy), 0);
    chk("cnt_end_remain", int'(remain), 0);

    // Zero duration: done the cycle after load, never busy
    do_load(6'd0);
    chk("ld0_busy", int'(busy), 0);
    step();
    chk("ld0_done_clear", int'(done), 0);

    // Abort beats load in the same cycle
    do_load(6'd2);
    chk("ab_busy_pre", int'(busy), 1);
    step();
    abort = 1'b1; load = 1'b1; load_val = 6'd7;
    step();
    abort = 1'b0; load = 1'b0;
    chk("ab_remain", int'(remain), 0);
    chk("ab_busy", int'(busy), 0);
    pulse(1'b0, '0, 1'b0);

    // Load coinciding with a tick wins
    do_load(6'd5);
    step();
    k = cyc;
    clk_1Hz = 1'b1;
    push(k + 3, 1'b1, 1'b0, 1'b1, 6'd5);
    wait_n(3);
    load = 1'b1; load_val = 6'd9;
    step();
    load = 1'b0;
    chk("ldtick_remain", int'(remain), 9);
    chk("ldtick_busy", int'(busy), 1);
    wait_n(22);
    clk_1Hz = 1'b0;
    wait_n(26);
    step(); abort = 1'b1; step(); abort = 1'b0;
    chk("ab2_remain", int'(remain), 0);

    // Load during the DONE cycle starts the next phase with no gap
    do_load(6'd1);
    step();
    k = cyc;
    clk_1Hz = 1'b1;
    push(k + 3, 1'b1, 1'b0, 1'b1, 6'd1);
    push(k + 4, 1'b0, 1'b1, 1'b0, '0);
    wait_n(4);
    load = 1'b1; load_val = 6'd2;
    step();
    load = 1'b0;
    chk("b2b_remain", int'(remain), 2);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_done", int'(done), 0);
    wait_n(21);
    clk_1Hz = 1'b0;
    wait_n(26);
    step(); abort = 1'b1; step(); abort = 1'b0;

`ifdef SEC_COUNTDOWN_BCD_EN
    do_load(6'd47);
    chk("bcd_tens47", int'(bcd_tens), 4);
    chk("bcd_ones47", int'(bcd_ones), 7);
    pulse(1'b1, 6'd47, 1'b0);
    chk("bcd_tens46", int'(bcd_tens), 4);
    chk("bcd_ones46", int'(bcd_ones), 6);
    step(); abort = 1'b1; step(); abort = 1'b0;
`endif

    // Reset mid-countdown: immediate clear, no done
    do_load(6'd4);
    pulse(1'b1, 6'd4, 1'b0);
    chk("mid_remain3", int'(remain), 3);
    step();
    res = 1'b1;
    #1;
    chk("midrst_remain", int'(remain), 0);
    chk("midrst_busy", int'(busy), 0);
    step();
    res = 1'b0;
    wait_n(60);
    chk("midrst_remain_hold", int'(remain), 0);

    chk("queue_empty", ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
